// File: rtl/wb_pkg.sv
// Shared types for the posted-write buffer: default widths, drain FSM states, entry layout.
package wb_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic                  valid;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_match.sv
// Youngest-match search over the circular entry array; the youngest entry sits just behind tail.
module wb_match #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]  valid_i,
    input  logic [ADDR_W-1:0] addr_i [DEPTH],
    input  logic [PW-1:0]     tail_i,
    input  logic [DEPTH-1:0]  excl_i,
    input  logic [ADDR_W-1:0] key_i,
    output logic              hit_o,
    output logic [PW-1:0]     idx_o
);

    logic [PW-1:0] pos;

    // Walk from youngest to oldest; the first qualifying match wins.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        pos   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            pos = tail_i - PW'(k + 1);
            if (!hit_o && valid_i[pos] && !excl_i[pos] && (addr_i[pos] == key_i)) begin
                hit_o = 1'b1;
                idx_o = pos;
            end
        end
    end

endmodule

// File: rtl/write_buffer.sv
// Posted-write FIFO between a write-through cache and memory, with youngest-entry read forwarding.
// Optional write coalescing into non-in-flight entries is enabled by defining WB_COALESCE_EN.
module write_buffer
    import wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_req,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   wr_ready,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic                   fwd_hit,
    output logic [DATA_W-1:0]      fwd_data,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic                   mem_ack,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    wb_state_e         state_q, state_d;

    logic          full;
    logic          do_push;
    logic          do_pop;
    logic          do_coal;
    logic          coal_hit;
    logic [PW-1:0] coal_idx;
    logic [PW-1:0] fwd_idx;

    assign full = (count_q == CW'(DEPTH));

    wb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fwd_match (
        .valid_i (valid_q),
        .addr_i  (addr_q),
        .tail_i  (tail_q),
        .excl_i  ('0),
        .key_i   (rd_addr),
        .hit_o   (fwd_hit),
        .idx_o   (fwd_idx)
    );

`ifdef WB_COALESCE_EN
    logic [DEPTH-1:0] in_flight;

    // The head being presented to memory may already be latched there, so it is never rewritten.
    always_comb begin
        in_flight = '0;
        if (state_q == ISSUE) in_flight[head_q] = 1'b1;
    end

    wb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_coal_match (
        .valid_i (valid_q),
        .addr_i  (addr_q),
        .tail_i  (tail_q),
        .excl_i  (in_flight),
        .key_i   (wr_addr),
        .hit_o   (coal_hit),
        .idx_o   (coal_idx)
    );

    assign wr_ready = !full || coal_hit;
`else
    assign coal_hit = 1'b0;
    assign coal_idx = '0;
    assign wr_ready = !full;
`endif

    // wr_ready uses the pre-cycle count, so a pop in the same cycle never frees a slot for a push.
    assign do_coal = wr_req && coal_hit;
    assign do_push = wr_req && !full && !coal_hit;
    assign do_pop  = (state_q == ISSUE) && mem_ack;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        state_d = state_q;

        if (do_coal) data_d[coal_idx] = wr_data;

        if (do_push) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = wr_addr;
            data_d[tail_q]  = wr_data;
            tail_d          = tail_q + PW'(1);
        end

        if (do_pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end

        count_d = count_q + CW'(do_push) - CW'(do_pop);

        case (state_q)
            IDLE:    if (count_q != '0) state_d = ISSUE;
            ISSUE:   if (count_d == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        if (rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= IDLE;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    assign mem_we    = (state_q == ISSUE);
    assign mem_addr  = addr_q[head_q];
    assign mem_wdata = data_q[head_q];
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign fwd_data  = fwd_hit ? data_q[fwd_idx] : '0;

endmodule

// File: tb/tb_write_buffer.sv
// Bench for write_buffer: directed scenarios plus random traffic against a queue-based reference model.
module tb_write_buffer;

    localparam int DEPTH = 4;
`ifdef WB_COALESCE_EN
    localparam bit COAL_EN = 1'b1;
`else
    localparam bit COAL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic [7:0]  rd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        empty;
    logic [2:0]  count;

    always #5 clk = ~clk;

    write_buffer #(.DEPTH(DEPTH), .ADDR_W(8), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_addr   (rd_addr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .empty     (empty),
        .count     (count)
    );

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];
    ent_t dut_log[$];
    bit   m_issue;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int m_fwd_idx(input logic [7:0] a);
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].a == a) return i;
        return -1;
    endfunction

    function automatic int m_coal_idx(input logic [7:0] a);
        for (int i = mq.size() - 1; i >= 0; i--)
            if (COAL_EN && mq[i].a == a && !(i == 0 && m_issue)) return i;
        return -1;
    endfunction

    // Called at the falling edge: drive inputs, compare, advance the model, cross one rising edge.
    task automatic step(input bit r, input bit wq, input logic [7:0] wa, input logic [31:0] wd,
                        input bit ack, input logic [7:0] ra);
        int fi, ci, old;
        bit full;
        rst = r; wr_req = wq; wr_addr = wa; wr_data = wd; mem_ack = ack; rd_addr = ra;
        #1;
        full = (mq.size() >= DEPTH);
        ci   = m_coal_idx(wa);
        fi   = m_fwd_idx(ra);
        chk("wr_ready", wr_ready, (!full || ci >= 0));
        chk("count", count, mq.size());
        chk("empty", empty, (mq.size() == 0));
        chk("mem_we", mem_we, m_issue);
        if (m_issue) begin
            chk("mem_addr", mem_addr, mq[0].a);
            chk("mem_wdata", mem_wdata, mq[0].d);
        end
        chk("fwd_hit", fwd_hit, (fi >= 0));
        chk("fwd_data", fwd_data, (fi >= 0) ? mq[fi].d : 32'h0);
        if (!r && mem_we && ack) dut_log.push_back('{mem_addr, mem_wdata});

        if (r) begin
            mq.delete();
            m_issue = 1'b0;
        end else begin
            old = mq.size();
            if (wq && ci >= 0) mq[ci].d = wd;
            else if (wq && !full) mq.push_back('{wa, wd});
            if (m_issue && ack) void'(mq.pop_front());
            m_issue = m_issue ? (mq.size() != 0) : (old != 0);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] a, input logic [31:0] d, input bit ack);
        step(1'b0, 1'b1, a, d, ack, 8'hFF);
    endtask

    task automatic idle(input bit ack);
        step(1'b0, 1'b0, 8'h00, 32'h0, ack, 8'h00);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 8'h00);
        dut_log.delete();
    endtask

    initial begin
        rst = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0; mem_ack = 1'b0; rd_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mq.delete();
        m_issue = 1'b0;

        // Reset state
        chk("rst_mem_we", mem_we, 0);
        chk("rst_empty", empty, 1);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_fwd_hit", fwd_hit, 0);
        chk("rst_fwd_data", fwd_data, 0);
        chk("rst_count", count, 0);

        // Single write: presented on the second edge after the push, for one cycle
        push(8'h10, 32'hDEADBEEF, 1'b1);
        chk("t1_we_early", mem_we, 0);
        idle(1'b1);
        chk("t1_we", mem_we, 1);
        chk("t1_addr", mem_addr, 8'h10);
        chk("t1_data", mem_wdata, 32'hDEADBEEF);
        idle(1'b1);
        chk("t1_we_done", mem_we, 0);
        chk("t1_empty", empty, 1);

        // Fill, reject a fifth write, then drain in order
        do_reset();
        for (int i = 1; i <= 4; i++) push(8'(i), 32'hA0 + i, 1'b0);
        chk("t2_count", count, 4);
        chk("t2_ready", wr_ready, 0);
        push(8'h05, 32'hA5, 1'b0);
        chk("t2_count_after5", count, 4);
        dut_log.delete();
        repeat (6) idle(1'b1);
        chk("t2_log_len", dut_log.size(), 4);
        for (int i = 0; i < 4 && i < dut_log.size(); i++) begin
            chk("t2_log_addr", dut_log[i].a, 8'(i + 1));
            chk("t2_log_data", dut_log[i].d, 32'hA1 + i);
        end

        // Forwarding returns the youngest match, zero on miss
        do_reset();
        push(8'h20, 32'h11, 1'b0);
        push(8'h20, 32'h22, 1'b0);
        rd_addr = 8'h20; #1;
        chk("t3_hit", fwd_hit, 1);
        chk("t3_data", fwd_data, 32'h22);
        rd_addr = 8'h21; #1;
        chk("t3_miss_hit", fwd_hit, 0);
        chk("t3_miss_data", fwd_data, 0);
        repeat (4) idle(1'b1);

        // Full with a concurrent pop: push refused this cycle, accepted next
        do_reset();
        for (int i = 0; i < 4; i++) push(8'h40 + 8'(i), 32'hB0 + i, 1'b0);
        idle(1'b0);
        wr_addr = 8'h48; #1;
        chk("t4_ready_full", wr_ready, 0);
        push(8'h48, 32'hB8, 1'b1);
        chk("t4_count_pop_only", count, 3);
        push(8'h48, 32'hB8, 1'b1);
        chk("t4_count_push_pop", count, 3);
        repeat (6) idle(1'b1);

        // Reset while issuing discards everything
        do_reset();
        push(8'h61, 32'h1, 1'b0);
        push(8'h62, 32'h2, 1'b0);
        push(8'h63, 32'h3, 1'b0);
        chk("t5_issuing", mem_we, 1);
        step(1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 8'h00);
        chk("t5_we", mem_we, 0);
        chk("t5_count", count, 0);
        chk("t5_empty", empty, 1);
        push(8'h70, 32'h77, 1'b1);
        idle(1'b1);
        chk("t5_restart_addr", mem_addr, 8'h70);
        chk("t5_restart_data", mem_wdata, 32'h77);
        repeat (2) idle(1'b1);

`ifdef WB_COALESCE_EN
        // Coalescing into a queued (non-head) entry
        do_reset();
        push(8'h30, 32'h1, 1'b0);
        push(8'h31, 32'h2, 1'b0);
        push(8'h31, 32'h3, 1'b0);
        chk("t6_count", count, 2);
        dut_log.delete();
        repeat (4) idle(1'b1);
        chk("t6_log_len", dut_log.size(), 2);
        if (dut_log.size() == 2) begin
            chk("t6_a0", dut_log[0].a, 8'h30);
            chk("t6_d0", dut_log[0].d, 32'h1);
            chk("t6_a1", dut_log[1].a, 8'h31);
            chk("t6_d1", dut_log[1].d, 32'h3);
        end
`endif

        // Random traffic over a small address range to provoke hits, fills and overlaps
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) != 0),
                 8'($urandom_range(0, 7)),
                 $urandom,
                 ($urandom_range(0, 1) == 1),
                 8'($urandom_range(0, 7)));
        end
        repeat (8) idle(1'b1);
        chk("final_empty", empty, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/write_buffer.md
Name: write_buffer

Overview:
- Posted-write FIFO between the write-through data cache and main memory.
- Cache write requests are accepted in one cycle and drained to memory in order, one entry at a time, under a memory ack handshake.
- Read addresses are checked against buffered entries. The youngest pending data is forwarded so cache refills never return stale memory contents.

Parameters:
DEPTH, 4, number of buffered writes (power of two, >=2)
ADDR_W, 8, word address width
DATA_W, 32, data width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
wr_req  input  1  cache requests a write this cycle
wr_addr  input  ADDR_W  write word address
wr_data  input  DATA_W  write data
wr_ready  output  1  buffer can accept wr_req this cycle
rd_addr  input  ADDR_W  address of current cache read/refill
fwd_hit  output  1  rd_addr matches a buffered entry
fwd_data  output  DATA_W  data of youngest matching entry, 0 when no hit
mem_we  output  1  head entry presented to memory
mem_addr  output  ADDR_W  head entry address
mem_wdata  output  DATA_W  head entry data
mem_ack  input  1  memory accepted the write this cycle (may be tied 1)
empty  output  1  no valid entries
count  output  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Storage: circular array of {valid, addr, data}; head/tail pointers wrap modulo DEPTH; count register.
- Reset (sync): all valid=0, head=tail=0, count=0, state=IDLE. Outputs become mem_we=0, empty=1, wr_ready=1, fwd_hit=0, count=0, fwd_data=0. Reset mid-drain discards all entries, including one being presented.
- Push: wr_req && wr_ready writes the tail entry and advances tail. wr_ready = (count != DEPTH) and is combinational from the registered count. No pass-through when full: wr_req while full and not coalescing is ignored. The cache must hold it.
- Drain FSM, state IDLE:
  - If count != 0, go to ISSUE next cycle.
  - Latency: a write pushed into an empty buffer drives mem_we=1 on the 2nd edge after the push.
- Drain FSM, state ISSUE:
  - mem_we=1; mem_addr/mem_wdata are the head entry, stable until ack.
  - On mem_ack: clear head valid, advance head.
  - If count after this cycle's push/pop is still nonzero, stay in ISSUE (back-to-back, one write per cycle with mem_ack tied 1). Otherwise go to IDLE.
- Simultaneous push and pop: count unchanged, both pointers advance. When full, a same-cycle pop does not enable a push (wr_ready uses the pre-cycle count).
- Forwarding: combinational over registered valid entries, including the head in ISSUE.
  - Among matches, the youngest entry (closest to tail) wins.
  - A wr_req in the same cycle is not visible until the next cycle.
- Ordering: memory sees writes in acceptance order; the same address may appear multiple times (without coalescing).
- Arithmetic: count never exceeds DEPTH or goes below 0; pointer wrap by truncation.

Optional Feature:
WB_COALESCE_EN.
- Defined:
  - A wr_req whose address matches a valid entry that is not the in-flight head (head while in ISSUE) overwrites that entry's data in place. count and tail are unchanged.
  - This is accepted even when full; wr_ready = !full || coalesce_match.
  - Matching the in-flight head appends normally.
- Undefined: every accepted write appends; no match logic on the write path.

Decomposition:
- Package wb_pkg holds ADDR_W/DATA_W defaults, the drain FSM state enum {IDLE, ISSUE}, and the entry struct {valid, addr, data}.
- One sub-module, wb_match: a parameterised youngest-match priority search over the entry array, given head/tail. It is reused for read forwarding and, when WB_COALESCE_EN is defined, write coalescing.

Test Plan:
- After reset, push (0x10, 0xDEADBEEF) with mem_ack=1 → mem_we high 2 edges later with mem_addr=0x10, mem_wdata=0xDEADBEEF for 1 cycle; empty=1 afterwards.
- mem_ack=0, push 4 writes (0x01..0x04 → 0xA1..0xA4) → count=4, wr_ready=0; a 5th wr_req is ignored. Raise mem_ack → memory sees 0x01..0x04 in order on 4 consecutive cycles.
- Push (0x20, 0x11) then (0x20, 0x22) with mem_ack=0; set rd_addr=0x20 → fwd_hit=1, fwd_data=0x22. rd_addr=0x21 → fwd_hit=0, fwd_data=0.
- Buffer full with mem_ack=1, wr_req asserted → no push on the full cycle; push accepted the following cycle; count stays ≤4 throughout.
- Assert rst while in ISSUE with 3 entries → next cycle mem_we=0, count=0, empty=1; subsequent pushes restart at index 0.
- With WB_COALESCE_EN, mem_ack=0: push (0x30, 0x1), (0x31, 0x2), (0x31, 0x3) → count=2; after ack, memory sees 0x30←0x1 and 0x31←0x3 only.
